// File: rtl/demux4_stream_pkg.sv
// Shared constants and types for the demux4_stream 1-to-4 stream demultiplexer.
// Build with DEMUX4_CNT_EN defined to add per-channel delivery counters.
package demux4_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(
        input logic [SEL_W-1:0] sel
    );
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux4_chan_buf.sv
// One output channel: single-entry holding buffer with load/drain control.
// DEMUX4_CNT_EN adds a wrapping count of completed output handshakes.
module demux4_chan_buf
    import demux4_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     d,
    input  logic             ready,
    output logic             valid,
    output logic [W-1:0]     data
`ifdef DEMUX4_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    buf_state_t state;

    assign valid = (state == FULL);

    // A load while FULL overwrites in place, so a same-cycle drain costs no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (load) begin
                        state <= FULL;
                        data  <= d;
                    end
                end
                FULL: begin
                    if (load) begin
                        data <= d;
                    end else if (ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX4_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: select decode and in_ready mux only.
// DEMUX4_CNT_EN exposes per-channel delivery counters cnt0..cnt3.
module demux4_stream
    import demux4_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s1,
    input  logic              s0,
    input  logic [W-1:0]      d,
    output logic [W-1:0]      o0,
    output logic [W-1:0]      o1,
    output logic [W-1:0]      o2,
    output logic [W-1:0]      o3,
    output logic [NUM_CH-1:0] o_valid,
    input  logic [NUM_CH-1:0] o_ready
`ifdef DEMUX4_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
`endif
);

    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] load;
    logic [W-1:0]      data [NUM_CH];
`ifdef DEMUX4_CNT_EN
    logic [CNT_W-1:0]  cnt [NUM_CH];
`endif

    assign sel = {s1, s0};

    // Only the targeted channel gates acceptance; no bypass around a stalled one.
    assign in_ready = !o_valid[sel] || o_ready[sel];
    assign load = (in_valid && in_ready) ? sel_onehot(sel) : '0;

    for (genvar j = 0; j < NUM_CH; j++) begin : g_ch
        demux4_chan_buf #(
            .W(W)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[j]),
            .d     (d),
            .ready (o_ready[j]),
            .valid (o_valid[j]),
            .data  (data[j])
`ifdef DEMUX4_CNT_EN
            ,
            .cnt   (cnt[j])
`endif
        );
    end

    assign o0 = data[CH0];
    assign o1 = data[CH1];
    assign o2 = data[CH2];
    assign o3 = data[CH3];

`ifdef DEMUX4_CNT_EN
    assign cnt0 = cnt[CH0];
    assign cnt1 = cnt[CH1];
    assign cnt2 = cnt[CH2];
    assign cnt3 = cnt[CH3];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream with a per-cycle channel-level reference model.
// Counter checks are compiled in when DEMUX4_CNT_EN is defined.
module tb_demux4_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       s1 = 1'b0;
    logic       s0 = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] o0, o1, o2, o3;
    logic [3:0] o_valid;
    logic [3:0] o_ready = 4'b0000;
`ifdef DEMUX4_CNT_EN
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux4_stream #(.W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s1       (s1),
        .s0       (s0),
        .d        (d),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
`ifdef DEMUX4_CNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
`endif
    );

    logic [7:0] oa [4];
    assign oa[0] = o0;
    assign oa[1] = o1;
    assign oa[2] = o2;
    assign oa[3] = o3;
`ifdef DEMUX4_CNT_EN
    logic [7:0] ca [4];
    assign ca[0] = cnt0;
    assign ca[1] = cnt1;
    assign ca[2] = cnt2;
    assign ca[3] = cnt3;
`endif

    // Reference: each channel is "holding a word or not", plus a delivery tally.
    bit       m_has [4];
    bit [7:0] m_word [4];
    int       m_deliv [4];
    bit       mon_en = 1'b0;

    function automatic bit model_ready(input logic [1:0] k, input logic [3:0] rdy);
        return !m_has[k] || rdy[k];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) begin
                m_has[j]   = 1'b0;
                m_word[j]  = 8'h00;
                m_deliv[j] = 0;
            end
        end else begin
            int tgt;
            bit take;
            tgt  = int'({s1, s0});
            take = in_valid && model_ready({s1, s0}, o_ready);
            for (int j = 0; j < 4; j++) begin
                if (m_has[j] && o_ready[j]) begin
                    m_deliv[j] = (m_deliv[j] + 1) % 256;
                    m_has[j] = 1'b0;
                end
                if (take && j == tgt) begin
                    m_has[j]  = 1'b1;
                    m_word[j] = d;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] mv;
            for (int j = 0; j < 4; j++) mv[j] = m_has[j];
            chk("mon_o_valid", int'(o_valid), int'(mv));
            chk("mon_in_ready", int'(in_ready), int'(model_ready({s1, s0}, o_ready)));
            for (int j = 0; j < 4; j++) begin
                if (m_has[j]) chk($sformatf("mon_o%0d", j), int'(oa[j]), int'(m_word[j]));
`ifdef DEMUX4_CNT_EN
                chk($sformatf("mon_cnt%0d", j), int'(ca[j]), m_deliv[j]);
`endif
            end
        end
    end

    // Producer rule: a stalled word must be held stable.
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word;
    always @(posedge clk) begin
        if (prev_stall && rst_n && in_valid)
            chk("producer_hold", int'({s1, s0, d}), int'(prev_word));
        prev_stall = rst_n && in_valid && !in_ready;
        prev_word  = {s1, s0, d};
    end

    // Delivery log for channel 1 during the streaming test.
    bit       cap_en = 1'b0;
    bit [7:0] cap_q [$];
    always @(negedge clk) begin
        if (cap_en && o_valid[1] && o_ready[1]) cap_q.push_back(o1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] w);
        in_valid = 1'b1;
        {s1, s0} = k;
        d = w;
    endtask

    initial begin
        // Reset held two cycles with a pending word.
        rst_n = 1'b0;
        send(2'd0, 8'hFF);
        o_ready = 4'b1111;
        step();
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        for (int j = 0; j < 4; j++) chk($sformatf("rst_o%0d", j), int'(oa[j]), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        mon_en = 1'b1;

        // Routing A0..A3 across channels 0..3.
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 8'hA0 + 8'(k));
            step();
            chk($sformatf("route_valid%0d", k), int'(o_valid), 1 << k);
            chk($sformatf("route_o%0d", k), int'(oa[k]), 8'hA0 + k);
        end
        in_valid = 1'b0;
        step();
        chk("route_idle", int'(o_valid), 0);

        // Backpressure on channel 2.
        o_ready = 4'b1011;
        send(2'd2, 8'h55);
        #1;
        chk("bp_first_ready", int'(in_ready), 1);
        step();
        chk("bp_hold_valid", int'(o_valid[2]), 1);
        chk("bp_hold_o2", int'(o2), 8'h55);
        d = 8'h66;
        #1;
        chk("bp_stall", int'(in_ready), 0);
        step();
        step();
        chk("bp_still_o2", int'(o2), 8'h55);
        chk("bp_still_stall", int'(in_ready), 0);
        o_ready = 4'b1111;
        #1;
        chk("bp_release", int'(in_ready), 1);
        step();
        chk("bp_swap_valid", int'(o_valid[2]), 1);
        chk("bp_swap_o2", int'(o2), 8'h66);
        in_valid = 1'b0;
        step();
        chk("bp_drained", int'(o_valid), 0);

        // Sixteen back-to-back words to channel 1.
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(2'd1, 8'h10 + 8'(i));
            #1;
            chk("stream_ready", int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        cap_en = 1'b0;
        chk("stream_count", cap_q.size(), 16);
        for (int i = 0; i < 16 && i < cap_q.size(); i++)
            chk($sformatf("stream_word%0d", i), int'(cap_q[i]), 8'h10 + i);

        // Mid-operation reset discards buffered words.
        o_ready = 4'b0000;
        send(2'd0, 8'hC0);
        step();
        send(2'd3, 8'hC3);
        step();
        in_valid = 1'b0;
        chk("mid_filled", int'(o_valid), 4'b1001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_o0", int'(o0), 0);
        chk("mid_rst_o3", int'(o3), 0);
        o_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_nothing", int'(o_valid), 0);
        end

`ifdef DEMUX4_CNT_EN
        // 257 deliveries on channel 0 wrap the counter to 1.
        for (int i = 0; i < 257; i++) begin
            send(2'd0, 8'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("cnt0_wrap", int'(cnt0), 1);
        chk("cnt1_zero", int'(cnt1), 0);
        chk("cnt2_zero", int'(cnt2), 0);
        chk("cnt3_zero", int'(cnt3), 0);
`endif

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
